// File: rtl/serial_bit_source.sv
// -----------------------------------------------------------------------------
// serial_bit_source
//   Parallel-in / serial-out bit-stream generator. Accepts WIDTH-bit words on a
//   valid/ready handshake and replays them one bit per bit_en strobe onto
//   `signal`, which feeds a downstream serial sequence detector.
//
//   Optional feature (compile-time macro SERIAL_PARITY_EN):
//     appends an even-parity bit (XOR of the data bits) after the last data
//     bit, so a frame lasts WIDTH+1 bit periods. Without the macro the PARITY
//     state and parity logic are not built and a frame is WIDTH bit periods.
//
// Parameters
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//   IDLE_LEVEL level on `signal` while no bit is being transmitted
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   din         parallel word to serialize
//   din_valid   din is valid this cycle
//   din_ready   word can be accepted this cycle (combinational)
//   bit_en      bit-rate strobe; the serial position advances only when high
//   signal      serial data out (registered)
//   sig_valid   signal carries a data/parity bit (registered)
//   busy        state is not IDLE
//   frame_done  one-cycle pulse after the final bit held its full period
// -----------------------------------------------------------------------------
module serial_bit_source #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             signal,
    output logic             sig_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
`ifdef SERIAL_PARITY_EN
        PARITY = 2'd2,
`endif
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;

    // All architectural state in one bundle: r is current, rn is next.
    typedef struct packed {
        state_t           state;
        logic [WIDTH-1:0] sreg;   // remaining bits, head bit is the one on signal
        logic [CW-1:0]    cnt;    // index of the bit currently on signal
        logic             sig;
        logic             sv;
        logic             fd;
`ifdef SERIAL_PARITY_EN
        logic             par;    // even parity of the loaded word
`endif
    } regs_t;

    regs_t r, rn;

    logic             frame_end;  // final bit of the frame ends at this edge
    logic             accept;
    logic [WIDTH-1:0] adv;        // shift register after one bit advance

    // Bit that goes out first from a word, given the transmit order.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign adv = (MSB_FIRST != 0) ? {r.sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, r.sreg[WIDTH-1:1]};

    // The accept window opens on the edge that retires the final bit, so a
    // waiting word follows with no idle gap.
`ifdef SERIAL_PARITY_EN
    assign frame_end = (r.state == PARITY) && bit_en;
`else
    assign frame_end = (r.state == SHIFT) && (r.cnt == LAST) && bit_en;
`endif

    assign din_ready = (r.state == IDLE) || frame_end;
    assign accept    = din_valid && din_ready;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r.state <= IDLE;
            r.sreg  <= '0;
            r.cnt   <= '0;
            r.sig   <= IDLE_LEVEL;
            r.sv    <= 1'b0;
            r.fd    <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r.par   <= 1'b0;
`endif
        end else begin
            r <= rn;
        end
    end

    // ------------------------------------------------------- next state/outputs
    always_comb begin
        rn    = r;
        rn.fd = 1'b0;
        if (accept) begin
            // Load takes priority; bit_en is irrelevant to the accept itself.
            rn.state = SHIFT;
            rn.sreg  = din;
            rn.cnt   = '0;
            rn.sig   = head(din);
            rn.sv    = 1'b1;
            rn.fd    = frame_end;
`ifdef SERIAL_PARITY_EN
            rn.par   = ^din;
`endif
        end else if (bit_en) begin
            case (r.state)
                SHIFT: begin
                    if (r.cnt == LAST) begin
`ifdef SERIAL_PARITY_EN
                        rn.state = PARITY;
                        rn.cnt   = '0;
                        rn.sig   = r.par;
`else
                        rn.state = IDLE;
                        rn.sreg  = '0;
                        rn.cnt   = '0;
                        rn.sig   = IDLE_LEVEL;
                        rn.sv    = 1'b0;
                        rn.fd    = 1'b1;
`endif
                    end else begin
                        rn.sreg = adv;
                        rn.cnt  = r.cnt + CW'(1);
                        rn.sig  = head(adv);
                    end
                end
`ifdef SERIAL_PARITY_EN
                PARITY: begin
                    rn.state = IDLE;
                    rn.sreg  = '0;
                    rn.cnt   = '0;
                    rn.sig   = IDLE_LEVEL;
                    rn.sv    = 1'b0;
                    rn.fd    = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign signal     = r.sig;
    assign sig_valid  = r.sv;
    assign frame_done = r.fd;
    assign busy       = (r.state != IDLE);

`ifndef SYNTHESIS
    // A bit is on the line exactly while a frame is in flight.
    a_sv_busy : assert property (@(posedge clk) disable iff (rst) sig_valid == busy);
    a_cnt_rng : assert property (@(posedge clk) disable iff (rst) r.cnt <= LAST);
    a_fd_once : assert property (@(posedge clk) disable iff (rst) frame_done |=> !frame_done);
`endif

endmodule

// File: tb/tb_serial_bit_source.sv
module tb_serial_bit_source;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       bit_en;

    logic rdy_m, sig_m, sv_m, busy_m, fd_m;
    logic rdy_l, sig_l, sv_l, busy_l, fd_l;

    int n_cmp = 0;
    int n_err = 0;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .bit_en(bit_en), .signal(sig_m), .sig_valid(sv_m), .busy(busy_m),
        .frame_done(fd_m)
    );

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .bit_en(bit_en), .signal(sig_l), .sig_valid(sv_l), .busy(busy_l),
        .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    // Minimal 101 detector on the LSB-first stream, clocked by the bit strobe.
    logic [1:0] hist;
    int         det_hits;
    logic       det_clr;
    always @(posedge clk) begin
        if (det_clr) begin
            hist     <= '0;
            det_hits <= 0;
        end else if (bit_en && sv_l) begin
            hist <= {hist[0], sig_l};
            if ({hist, sig_l} == 3'b101) det_hits <= det_hits + 1;
        end
    end

    // One cycle of stimulus and the outputs it must produce: rdy is checked
    // before the edge, the rest after it.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       en;
        logic       rdy;
        logic       sig;
        logic       sv;
        logic       fd;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d, input logic en,
                       input logic rdy, input logic sig, input logic sv,
                       input logic fd, input logic bz);
        vec_t e;
        e.v = v; e.d = d; e.en = en; e.rdy = rdy;
        e.sig = sig; e.sv = sv; e.fd = fd; e.busy = bz;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run(input string name, input bit lsb);
        for (int i = 0; i < tbl.size(); i++) begin
            din       = tbl[i].d;
            din_valid = tbl[i].v;
            bit_en    = tbl[i].en;
            #1;
            chk({name, ".din_ready"}, i, lsb ? rdy_l : rdy_m, tbl[i].rdy);
            @(posedge clk);
            @(negedge clk);
            chk({name, ".signal"},     i, lsb ? sig_l  : sig_m,  tbl[i].sig);
            chk({name, ".sig_valid"},  i, lsb ? sv_l   : sv_m,   tbl[i].sv);
            chk({name, ".frame_done"}, i, lsb ? fd_l   : fd_m,   tbl[i].fd);
            chk({name, ".busy"},       i, lsb ? busy_l : busy_m, tbl[i].busy);
        end
        tbl.delete();
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, ".signal"},     0, sig_m,  1'b0);
        chk({name, ".sig_valid"},  0, sv_m,   1'b0);
        chk({name, ".busy"},       0, busy_m, 1'b0);
        chk({name, ".frame_done"}, 0, fd_m,   1'b0);
        chk({name, ".din_ready"},  0, rdy_m,  1'b1);
        chk({name, ".busy_l"},     0, busy_l, 1'b0);
    endtask

    initial begin
        logic [7:0]  seq8;
        logic [15:0] seq16;

        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        bit_en    = 1'b0;
        det_clr   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // ---- single word, MSB first, bit_en always high
        seq8 = 8'b1011_0000;
        add(1'b1, 8'hB0, 1'b1, 1'b1, seq8[7], 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++)
            add(1'b0, 8'h00, 1'b1, 1'b0, seq8[7-k], 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_PARITY_EN
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("single", 1'b0);

        // ---- back-to-back A5 then 0F, valid held
        seq16 = 16'b10100101_00001111;
        add(1'b1, 8'hA5, 1'b1, 1'b1, seq16[15], 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++)
            add(1'b1, 8'h0F, 1'b1, 1'b0, seq16[15-k], 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_PARITY_EN
        add(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        add(1'b1, 8'h0F, 1'b1, 1'b1, seq16[7], 1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 8; k++)
            add(1'b0, 8'h00, 1'b1, 1'b0, seq16[7-k], 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_PARITY_EN
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("b2b", 1'b0);

        // ---- bit_en every 3rd cycle, LSB first, 0000_0101
        det_clr = 1'b0;
        seq8 = 8'b0000_0101;
        add(1'b1, 8'h05, 1'b0, 1'b1, seq8[0], 1'b1, 1'b0, 1'b1);
        for (int j = 1; j < 24; j++)
            add(1'b0, 8'h00, (j % 3 == 0), 1'b0, seq8[j/3], 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_PARITY_EN
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rate", 1'b1);
        n_cmp++;
        if (det_hits != 1) begin
            n_err++;
            $display("FAIL det101: got %0d hits expected 1", det_hits);
        end

        // ---- reset after the 4th bit of FF, then a clean 80 frame
        add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        run("prerst", 1'b0);
        din_valid = 1'b0;
        bit_en    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_PARITY_EN
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("postrst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
